// File: rtl/ann_weight_pkg.sv
// Shared definitions for the ANN weight BRAM sequencer: default widths,
// controller state encoding and pass-mode constants.
package ann_weight_pkg;

    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 5;
    localparam int DEPTH_DEF = 28;

    localparam logic MODE_READ = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DRAIN,
        LOAD,
        FIN
    } state_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry skid FIFO carrying {last, data} between the BRAM read port and
// the weight stream; the head is presented directly on o_head.
module weight_skid_fifo
    import ann_weight_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [DW:0]   i_push_data,
    input  logic          i_pop,
    output logic [DW:0]   o_head,
    output logic          o_valid,
    output logic [1:0]    o_count
);

    logic [DW:0] r_mem [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && (r_count != 2'd2);
    assign w_do_pop  = i_pop  && (r_count != 2'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the head is forced to zero
    // whenever the FIFO is empty, so stale contents are never observable.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_valid = (r_count != 2'd0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/weight_bram_sequencer.sv
// Sequences one single-port weight BRAM: READ passes stream all words to the
// MAC over valid/ready, LOAD passes write a run-time weight stream into it.
module weight_bram_sequencer
    import ann_weight_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          MODE,
    input  logic          ABORT,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] BRAM_ADDR,
    output logic [DW-1:0] BRAM_DI,
    output logic          BRAM_EN,
    output logic          BRAM_WE,
    input  logic [DW-1:0] BRAM_DO,
    output logic [DW-1:0] W_DATA,
    output logic          W_VALID,
    input  logic          W_READY,
    output logic          W_LAST,
    input  logic [DW-1:0] LD_DATA,
    input  logic          LD_VALID,
    output logic          LD_READY
);

    localparam logic [AW:0] LAST_ADDR = (AW + 1)'(DEPTH - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW:0]   r_cnt;
    logic          r_inflight;
    logic          r_inflight_last;
    logic          r_bram_en;
    logic          r_bram_we;
    logic [AW-1:0] r_bram_addr;
    logic [DW-1:0] r_bram_di;

    logic [DW:0]   w_fifo_head;
    logic          w_fifo_valid;
    logic [1:0]    w_fifo_count;
    logic          w_pop;
    logic [2:0]    w_slots;
    logic          w_drained;
    logic          w_at_last;
    logic          w_start;
    logic          w_issue_rd;
    logic          w_issue_wr;

    assign w_pop     = w_fifo_valid && W_READY;
    assign w_at_last = (r_cnt == LAST_ADDR);

    // Slots still committed after this cycle's pop; counting the pop keeps
    // one word per cycle flowing while never overfilling the FIFO.
    assign w_slots   = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_drained = !r_inflight &&
                       ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop));

    weight_skid_fifo #(.DW(DW)) u_skid (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_flush     (ABORT),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, BRAM_DO}),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_valid     (w_fifo_valid),
        .o_count     (w_fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_issue_rd = 1'b0;
        w_issue_wr = 1'b0;
        case (r_state)
            IDLE: begin
                if (START && !ABORT) begin
                    w_start = 1'b1;
                    w_next  = (MODE == MODE_LOAD) ? LOAD : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (ABORT) begin
                    w_next = IDLE;
                end else if (w_slots < 3'd2) begin
                    w_issue_rd = 1'b1;
                    if (w_at_last) w_next = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (ABORT)          w_next = IDLE;
                else if (w_drained) w_next = FIN;
            end
            LOAD: begin
                if (ABORT) begin
                    w_next = IDLE;
                end else if (LD_VALID) begin
                    w_issue_wr = 1'b1;
                    if (w_at_last) w_next = FIN;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_bram_en       <= 1'b0;
            r_bram_we       <= 1'b0;
            r_bram_addr     <= '0;
            r_bram_di       <= '0;
        end else begin
            r_bram_en  <= w_issue_rd || w_issue_wr;
            r_bram_we  <= w_issue_wr;
            r_inflight <= w_issue_rd;
            if (w_issue_rd) r_inflight_last <= w_at_last;
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_issue_rd || w_issue_wr) begin
                r_cnt       <= r_cnt + 1'b1;
                r_bram_addr <= r_cnt[AW-1:0];
            end
            if (w_issue_wr) r_bram_di <= LD_DATA;
        end
    end

    assign BUSY      = (r_state != IDLE);
    assign DONE      = (r_state == FIN);
    assign BRAM_EN   = r_bram_en;
    assign BRAM_WE   = r_bram_we;
    assign BRAM_ADDR = r_bram_addr;
    assign BRAM_DI   = r_bram_di;
    assign W_DATA    = w_fifo_head[DW-1:0];
    assign W_LAST    = w_fifo_head[DW];
    assign W_VALID   = w_fifo_valid;
    assign LD_READY  = (r_state == LOAD) && !ABORT;

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Directed bench for weight_bram_sequencer with a negedge-clocked BRAM model.
module tb_weight_bram_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        MODE = 1'b0;
    logic        ABORT = 1'b0;
    logic        BUSY, DONE;
    logic [4:0]  BRAM_ADDR;
    logic [15:0] BRAM_DI;
    logic        BRAM_EN, BRAM_WE;
    logic [15:0] BRAM_DO = '0;
    logic [15:0] W_DATA;
    logic        W_VALID;
    logic        W_READY = 1'b0;
    logic        W_LAST;
    logic [15:0] LD_DATA = '0;
    logic        LD_VALID = 1'b0;
    logic        LD_READY;

    logic [15:0] mem [0:31];
    logic        tb_we = 1'b0;
    logic [4:0]  tb_addr = '0;
    logic [15:0] tb_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    weight_bram_sequencer dut (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .ABORT(ABORT),
        .BUSY(BUSY), .DONE(DONE),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_DI(BRAM_DI), .BRAM_EN(BRAM_EN),
        .BRAM_WE(BRAM_WE), .BRAM_DO(BRAM_DO),
        .W_DATA(W_DATA), .W_VALID(W_VALID), .W_READY(W_READY), .W_LAST(W_LAST),
        .LD_DATA(LD_DATA), .LD_VALID(LD_VALID), .LD_READY(LD_READY)
    );

    always @(negedge CLK) begin
        if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (BRAM_EN) begin
            if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
            BRAM_DO <= BRAM_WE ? BRAM_DI : mem[BRAM_ADDR];
        end
    end

    task automatic check(input logic ok, input string msg);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s", msg);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic preload(input logic [15:0] base);
        for (int i = 0; i < 32; i++) begin
            tb_addr = 5'(i);
            tb_data = base + 16'(i);
            tb_we   = 1'b1;
            @(negedge CLK);
            #1;
        end
        tb_we = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        check({BUSY, DONE, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI, W_VALID, W_LAST, W_DATA, LD_READY} === '0,
              $sformatf("reset_outputs got=%h want=0",
                        {BUSY, DONE, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI, W_VALID, W_LAST, W_DATA, LD_READY}));
        RST = 1'b0;
        step();
        check(BUSY === 1'b0 && DONE === 1'b0,
              $sformatf("reset_release_idle busy=%b done=%b want=0,0", BUSY, DONE));
    endtask

    // pat 0: W_READY always high; pat 1: W_READY follows 1,0,0,1 repeating.
    task automatic run_read(input int pat, input logic [15:0] base, input string name);
        int   idx = 0;
        int   issued = 0;
        int   popped = 0;
        int   last_hs = -10;
        logic done_seen = 1'b0;
        logic rdy;
        MODE  = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            if (BRAM_EN) begin
                check(BRAM_WE === 1'b0 && BRAM_ADDR === 5'(issued),
                      $sformatf("%s_rd_issue cyc=%0d we=%b addr=%0d want we=0 addr=%0d",
                                name, cyc, BRAM_WE, BRAM_ADDR, issued));
                issued++;
            end
            check(issued - popped <= 2,
                  $sformatf("%s_outstanding cyc=%0d got=%0d want<=2", name, cyc, issued - popped));
            if (DONE) begin
                done_seen = 1'b1;
                check(idx == 28 && cyc == last_hs + 1,
                      $sformatf("%s_done cyc=%0d words=%0d want cyc=%0d words=28",
                                name, cyc, idx, last_hs + 1));
            end
            if (pat == 0) begin
                check(W_VALID === (cyc >= 2 && cyc < 30),
                      $sformatf("%s_valid_timing cyc=%0d got=%b want=%b",
                                name, cyc, W_VALID, (cyc >= 2 && cyc < 30)));
            end
            if (W_VALID) begin
                check(W_DATA === base + 16'(idx) && W_LAST === (idx == 27),
                      $sformatf("%s_word cyc=%0d data=%h last=%b want data=%h last=%b",
                                name, cyc, W_DATA, W_LAST, base + 16'(idx), (idx == 27)));
            end
            rdy     = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            W_READY = rdy;
            if (W_VALID && rdy) begin
                idx++;
                popped++;
                last_hs = cyc;
            end
            step();
        end
        W_READY = 1'b0;
        check(done_seen && BUSY === 1'b0,
              $sformatf("%s_completion done_seen=%b busy=%b want 1,0", name, done_seen, BUSY));
    endtask

    task automatic test_read_stream();
        preload(16'h0000);
        run_read(0, 16'h0000, "read_stream");
    endtask

    task automatic test_read_backpressure();
        run_read(1, 16'h0000, "read_bp");
    endtask

    task automatic test_abort();
        logic found = 1'b0;
        W_READY = 1'b1;
        MODE    = 1'b0;
        START   = 1'b1;
        step();
        START = 1'b0;
        for (int cyc = 0; cyc < 60 && !found; cyc++) begin
            if (W_VALID && W_DATA == 16'd10) found = 1'b1;
            else step();
        end
        check(found, "abort_reach_word10 got=timeout want=word 10");
        ABORT   = 1'b1;
        W_READY = 1'b0;
        step();
        ABORT = 1'b0;
        check({BUSY, W_VALID, DONE, BRAM_EN} === 4'b0000,
              $sformatf("abort_idle busy=%b valid=%b done=%b en=%b want 0000",
                        BUSY, W_VALID, DONE, BRAM_EN));
        for (int i = 0; i < 3; i++) begin
            step();
            check(DONE === 1'b0 && BUSY === 1'b0 && W_VALID === 1'b0,
                  $sformatf("abort_quiet i=%0d done=%b busy=%b valid=%b want 0,0,0",
                            i, DONE, BUSY, W_VALID));
        end
        run_read(0, 16'h0000, "read_after_abort");
    endtask

    task automatic test_load();
        int   acc = 0;
        int   wr_seen = 0;
        int   last_acc = -10;
        logic done_seen = 1'b0;
        MODE  = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        MODE  = 1'b0;
        for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            if (BRAM_EN) begin
                check(BRAM_WE === 1'b1 && BRAM_ADDR === 5'(wr_seen) && BRAM_DI === 16'hA000 + 16'(wr_seen),
                      $sformatf("load_write cyc=%0d we=%b addr=%0d di=%h want we=1 addr=%0d di=%h",
                                cyc, BRAM_WE, BRAM_ADDR, BRAM_DI, wr_seen, 16'hA000 + 16'(wr_seen)));
                wr_seen++;
            end
            if (DONE) begin
                done_seen = 1'b1;
                check(acc == 28 && LD_READY === 1'b0 && cyc == last_acc + 1,
                      $sformatf("load_done cyc=%0d accepts=%0d ld_ready=%b want cyc=%0d accepts=28 ld_ready=0",
                                cyc, acc, LD_READY, last_acc + 1));
            end else begin
                check(LD_READY === 1'b1,
                      $sformatf("load_ready cyc=%0d got=%b want=1", cyc, LD_READY));
            end
            LD_VALID = (cyc % 3 != 2) && (acc < 28) && !done_seen;
            LD_DATA  = 16'hA000 + 16'(acc);
            if (LD_VALID && LD_READY) begin
                acc++;
                last_acc = cyc;
            end
            step();
        end
        LD_VALID = 1'b0;
        check(done_seen && wr_seen == 28 && BUSY === 1'b0,
              $sformatf("load_completion done_seen=%b writes=%0d busy=%b want 1,28,0",
                        done_seen, wr_seen, BUSY));
        for (int i = 0; i < 28; i++) begin
            check(mem[i] === 16'hA000 + 16'(i),
                  $sformatf("load_bram addr=%0d got=%h want=%h", i, mem[i], 16'hA000 + 16'(i)));
        end
        run_read(0, 16'hA000, "read_after_load");
    endtask

    task automatic test_busy_start_and_rst();
        int acc = 0;
        MODE  = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int cyc = 0; cyc < 40 && acc < 5; cyc++) begin
            check(LD_READY === 1'b1 && BUSY === 1'b1,
                  $sformatf("busy_start_ignored cyc=%0d ld_ready=%b busy=%b want 1,1",
                            cyc, LD_READY, BUSY));
            if (BRAM_EN) begin
                check(BRAM_WE === 1'b1,
                      $sformatf("busy_start_no_read cyc=%0d we=%b want=1", cyc, BRAM_WE));
            end
            START    = (cyc == 1);
            MODE     = 1'b0;
            LD_VALID = 1'b1;
            LD_DATA  = 16'hB000 + 16'(acc);
            if (LD_READY) acc++;
            step();
        end
        START    = 1'b0;
        LD_VALID = 1'b0;
        RST      = 1'b1;
        step();
        check({BUSY, DONE, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI, W_VALID, W_LAST, W_DATA, LD_READY} === '0,
              $sformatf("rst_mid_load got=%h want=0",
                        {BUSY, DONE, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI, W_VALID, W_LAST, W_DATA, LD_READY}));
        RST = 1'b0;
        step();
        check(BUSY === 1'b0 && BRAM_EN === 1'b0 && LD_READY === 1'b0,
              $sformatf("rst_release busy=%b en=%b ld_ready=%b want 0,0,0", BUSY, BRAM_EN, LD_READY));
        check(mem[4] === 16'hB004 && mem[5] === 16'hA005,
              $sformatf("rst_bram_contents m4=%h m5=%h want B004 A005", mem[4], mem[5]));
    endtask

    task automatic test_start_abort_idle();
        MODE  = 1'b0;
        START = 1'b1;
        ABORT = 1'b1;
        step();
        START = 1'b0;
        ABORT = 1'b0;
        check(BUSY === 1'b0 && BRAM_EN === 1'b0,
              $sformatf("start_abort_idle busy=%b en=%b want 0,0", BUSY, BRAM_EN));
        step();
        check(BUSY === 1'b0 && W_VALID === 1'b0 && BRAM_EN === 1'b0,
              $sformatf("start_abort_stay busy=%b valid=%b en=%b want 0,0,0", BUSY, W_VALID, BRAM_EN));
    endtask

    initial begin
        test_reset();
        test_read_stream();
        test_read_backpressure();
        test_abort();
        test_load();
        test_busy_start_and_rst();
        test_start_abort_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_bram_sequencer.md
Name: weight_bram_sequencer

Overview:
- Controller that sequences one single-port weight BRAM for an ANN neuron.
- The BRAM is 16-bit × DEPTH. It samples EN/WE/ADDR/DI on the negedge of CLK and drives registered DO on that same negedge.
- READ pass: streams all DEPTH weights in address order to the MAC datapath over a valid/ready handshake with backpressure.
- LOAD pass: writes DEPTH weights from a load stream into the BRAM at run time.
- Sits between the layer controller (start/mode/done) and one weight BRAM instance.

Parameters:
- DEPTH, 28, number of weight words per neuron (addresses 0..DEPTH-1).
- AW, 5, BRAM address width; must satisfy 2^AW >= DEPTH.
- DW, 16, weight word width.

Ports:
- CLK  in  1  clock; all controller flops on posedge.
- RST  in  1  synchronous active-high reset.
- START  in  1  one-cycle pulse; begins a pass. Ignored unless IDLE.
- MODE  in  1  sampled with START: 0 = READ pass, 1 = LOAD pass.
- ABORT  in  1  terminates the current pass; returns to IDLE next cycle with no DONE.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse when a pass completes.
- BRAM_ADDR  out  AW  BRAM address.
- BRAM_DI  out  DW  BRAM write data.
- BRAM_EN  out  1  BRAM enable.
- BRAM_WE  out  1  BRAM write enable.
- BRAM_DO  in  DW  BRAM read data.
- W_DATA  out  DW  weight to datapath.
- W_VALID  out  1  W_DATA valid.
- W_READY  in  1  datapath accepts.
- W_LAST  out  1  high with the word from address DEPTH-1.
- LD_DATA  in  DW  weight to write.
- LD_VALID  in  1  LD_DATA valid.
- LD_READY  out  1  controller accepts LD_DATA.

Behaviour:
- Reset values: BUSY=0, DONE=0, BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_DI=0, W_VALID=0, W_LAST=0, W_DATA=0, LD_READY=0. State=IDLE, skid buffer empty, address counter 0.
- All BRAM_* outputs are registered on posedge. The BRAM acts on the following negedge.
- Read timing: a read issued at posedge k has BRAM_DO stable by posedge k+1, where the controller captures it. Read latency is 1 cycle; one read at most is in flight.
- States:
  - IDLE.
  - RD_ISSUE: address counter < DEPTH.
  - RD_DRAIN: all reads issued; skid buffer not yet empty.
  - LOAD.
  - FIN: 1 cycle; DONE=1; then IDLE.
- IDLE + START: MODE=0 → RD_ISSUE; MODE=1 → LOAD. Address counter cleared to 0.
- READ output path:
  - 2-entry skid FIFO feeds W_DATA/W_VALID; W_DATA is the FIFO head.
  - A read is issued (BRAM_EN=1, WE=0, ADDR=counter; counter +1) only if (FIFO occupancy + in-flight) < 2. This guarantees no captured word is ever dropped.
  - Sustained throughput is 1 word/cycle when W_READY is held high. First W_VALID appears 2 cycles after START.
  - When the counter reaches DEPTH, go to RD_DRAIN.
  - When the FIFO empties with nothing in flight, go to FIN.
  - W_LAST is tagged on the entry read from DEPTH-1.
- W_VALID, once asserted, stays high with stable W_DATA until W_READY.
- LOAD:
  - LD_READY=1 in LOAD.
  - On LD_VALID & LD_READY: register BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=counter, BRAM_DI=LD_DATA; counter +1.
  - After the write of address DEPTH-1 is issued, LD_READY drops and the state goes to FIN. The write lands on the following negedge, before DONE is seen.
- BRAM_EN/WE are high only in cycles where an access is issued; otherwise both are 0.
- START while BUSY: ignored.
- ABORT in any busy state:
  - Next state IDLE; FIFO flushed; W_VALID=0; in-flight read discarded; no DONE.
  - ABORT has priority over START and over completion in the same cycle.
- RST mid-pass: same as ABORT, plus all registers go to their reset values. A write already issued may still land on the next negedge; this is acceptable.
- Counter width is AW+1 so the compare against DEPTH cannot wrap.

Decomposition:
- Shared package ann_weight_pkg holds:
  - DW and AW defaults;
  - the state encoding (IDLE, RD_ISSUE, RD_DRAIN, LOAD, FIN);
  - MODE_READ=0 and MODE_LOAD=1 constants.
- One sub-module, weight_skid_fifo: 2-entry DW+1-bit (data+last) FIFO with push/pop/flush and occupancy output.

Test Plan:
- READ, W_READY=1 constantly, BRAM preloaded with value = address → W_DATA sequence 0..27 on 28 consecutive cycles starting START+2; W_LAST only on 27; DONE one cycle after the last handshake.
- READ with W_READY toggling 1,0,0,1 pattern → every word 0..27 delivered exactly once, in order; W_DATA stable while stalled; never more than 2 reads outstanding.
- LOAD with LD_DATA = 16'hA000+i and LD_VALID gaps every third cycle → BRAM contains A000..A01B; LD_READY low after the 28th accept; DONE pulses; a follow-up READ returns A000..A01B.
- ABORT at word 10 of a READ → IDLE next cycle; W_VALID=0; no DONE. New START then streams from address 0.
- START pulsed while BUSY, and RST asserted mid-LOAD at word 5 → START ignored; after RST all outputs at reset values and BUSY=0.
- START and ABORT in the same IDLE cycle → remains IDLE; BUSY stays 0.
